// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester: state encoding and default sizing.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StReq  = ST_REQ,
    StXfer = ST_XFER,
    StHold = ST_HOLD
  } arb_state_e;

  localparam int unsigned DefaultLenW    = 4;
  localparam int unsigned DefaultTimeout = 16;
  localparam int unsigned DefaultHoldoff = 1;

endpackage

// File: rtl/arb_req_timer.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
// Loading N-1 and decrementing while enabled gives N enabled cycles before expiry.
module arb_req_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/arb_requester.sv
// Client-side initiator for the two-port request/grant arbiter. A beat is taken on each
// granted XFER cycle and reported on the registered beat_* outputs in the following cycle.
// Define ARB_REQ_TIMEOUT_EN to abort a grant wait after TIMEOUT REQ cycles.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W   = DefaultLenW,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned HOLDOFF = DefaultHoldoff
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic             beat_last,
  output logic [LEN_W-1:0] beat_idx,
  output logic             busy,
  output logic             timeout_err
);

`ifdef ARB_REQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam int unsigned TmrMax = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] HoldLoad    = TmrW'(HOLDOFF - 1);
  localparam logic [TmrW-1:0] TimeoutLoad = TmrW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
  logic             first_q, first_d;
  logic             beat_valid_q, beat_valid_d;
  logic             beat_last_q, beat_last_d;
  logic             terr_q, terr_d;
  logic             tmr_load, tmr_en, tmr_expired;
  logic [TmrW-1:0]  tmr_val;

  // One timer serves both the grant wait (REQ) and the holdoff (HOLD).
  arb_req_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  assign tmr_en = (state_q == StReq) || (state_q == StHold);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    first_d      = 1'b0;
    beat_valid_d = 1'b0;
    beat_last_d  = 1'b0;
    beat_idx_d   = beat_idx_q;
    terr_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = HoldLoad;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          len_d   = cmd_len;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = StReq;
          if (TimeoutEn) begin
            tmr_load = 1'b1;
            tmr_val  = TimeoutLoad;
          end
        end
      end
      StReq: begin
        // The first REQ cycle sees a grant registered before req rose, so skip it.
        if (!first_q && gnt) begin
          state_d = StXfer;
        end else if (TimeoutEn && tmr_expired) begin
          terr_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = StHold;
        end
      end
      StXfer: begin
        if (gnt) begin
          beat_valid_d = 1'b1;
          beat_idx_d   = cnt_q;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == len_q) begin
            beat_last_d = 1'b1;
            tmr_load    = 1'b1;
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (tmr_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_idx_q   <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      beat_valid_q <= beat_valid_d;
      beat_last_q  <= beat_last_d;
      beat_idx_q   <= beat_idx_d;
      terr_q       <= terr_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign req         = (state_q == StReq) || (state_q == StXfer);
  assign busy        = (state_q != StIdle);
  assign beat_valid  = beat_valid_q;
  assign beat_last   = beat_last_q;
  assign beat_idx    = beat_idx_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side initiator for the two-port request/grant arbiter. One instance sits in front of each arbiter port.
- Accepts a burst command from upstream over a valid/ready handshake, then raises req and waits for gnt.
- Issues one beat per granted cycle until the burst completes, then releases req for one holdoff cycle so the other requester can win.
- The arbiter's gnt is registered and keeps its last value when no request is pending, so this block filters stale grants.

Parameters:
- LEN_W, 4, width of the burst-length field; burst = cmd_len+1 beats (1..2^LEN_W).
- TIMEOUT, 16, max REQ-state cycles to wait for grant before abort (only with ARB_REQ_TIMEOUT_EN).
- HOLDOFF, 1, cycles req stays low after a burst before the next command is accepted (>=1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low: reset==0 at a rising clock edge resets all state.
- cmd_valid  input  1  upstream command valid.
- cmd_len  input  LEN_W  beats minus one.
- cmd_ready  output  1  block can accept a command (IDLE only).
- req  output  1  request to the arbiter (req_0 or req_1).
- gnt  input  1  grant from the arbiter (gnt_0 or gnt_1).
- beat_valid  output  1  one transfer beat this cycle.
- beat_last  output  1  final beat of the burst; only asserted with beat_valid.
- beat_idx  output  LEN_W  index of the current beat, 0-based.
- busy  output  1  state != IDLE.
- timeout_err  output  1  one-cycle pulse on grant-wait abort.

Behaviour:
- All outputs are registered. Reset values: req=0, beat_valid=0, beat_last=0, beat_idx=0, timeout_err=0, busy=0, cmd_ready=1 (IDLE).
- Reset mid-burst forces IDLE on the next edge. req drops in that same cycle; no beat_last is emitted.
- States: IDLE, REQ, XFER, HOLD.
- IDLE: cmd_ready=1. When cmd_valid=1:
  - latch cmd_len into len_q; clear beat counter and wait counter;
  - next state REQ; req=1 from the next cycle.
- REQ: req=1.
  - gnt is ignored in the first REQ cycle, because the registered grant may be stale.
  - From the second REQ cycle, gnt=1 -> XFER. The first beat is in the first XFER cycle if gnt is still 1.
- XFER: req=1. Each cycle with gnt=1:
  - beat_valid=1, beat_idx=counter;
  - counter increments; beat_last=1 when counter==len_q.
  - The beat_last cycle is followed by HOLD.
  - gnt=0 mid-burst: no beat, counter holds, req stays high, remain in XFER (preemption pause).
- HOLD: req=0 for HOLDOFF cycles, then IDLE. cmd_valid is ignored during HOLD.
- Counter width: LEN_W; the LEN_W-bit comparison is exact and never wraps within a burst.
- Max burst (cmd_len all ones) ends at beat_idx=2^LEN_W-1.
- cmd_len=0: a single beat with beat_valid and beat_last both 1.
- Simultaneous gnt rise and timeout expiry: the grant wins, go to XFER, no timeout_err.

Optional Feature:
- Macro ARB_REQ_TIMEOUT_EN.
- Defined: a wait counter runs in REQ. When it reaches TIMEOUT cycles without an accepted grant:
  - req drops next cycle and timeout_err pulses once;
  - the state goes to HOLD (not IDLE), and the command is discarded.
- Undefined: no wait counter; REQ waits indefinitely and timeout_err is tied 0.

Decomposition:
- Shared package arb_pkg:
  - state encoding localparams (ST_IDLE=2'd0, ST_REQ=2'd1, ST_XFER=2'd2, ST_HOLD=2'd3);
  - default LEN_W/TIMEOUT values.
- One natural sub-module: arb_req_timer, a loadable down-counter with an expire flag, reused for HOLDOFF and TIMEOUT. Without the macro it is instanced only for HOLD.

Test Plan:
- Reset low for 2 cycles during XFER at beat 3 -> next edge req=0, busy=0, cmd_ready=1, no beat_last.
- cmd_len=3, gnt rises 1 cycle after req and holds -> 4 beats, idx 0..3, beat_last on idx 3, then req=0 for 1 cycle, then cmd_ready=1.
- gnt already 1 (stale) when the command is accepted, cmd_len=0 -> no beat in the first REQ cycle. Exactly one beat with beat_last in the first XFER cycle.
- cmd_len=5, gnt drops for 3 cycles after beat 2 -> req stays 1, no beats while gnt=0. Beats 3..5 resume; 6 beats total.
- Two instances on the arbiter, both with cmd_len=1 -> port 0 completes its 2 beats. Port 1 is granted during port 0's HOLD and completes 2 beats.
- ARB_REQ_TIMEOUT_EN, TIMEOUT=16, gnt held 0 -> timeout_err pulses once after 16 REQ cycles, req falls, no beats. A second command is accepted only after HOLD.
